// File: rtl/miriscv_decode_pkg.sv
// RV32 major opcodes and source-register usage helpers for the decode stage.
package miriscv_decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    case (opcode)
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: uses_rs1 = 1'b1;
      default:                                                       uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      OPC_BRANCH, OPC_STORE, OPC_OP: uses_rs2 = 1'b1;
      default:                       uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/miriscv_pkg.sv
// Core-wide defaults shared by the miriscv front-end blocks.
package miriscv_pkg;

  localparam int unsigned XLEN_DEFAULT       = 32;
  localparam int unsigned ILEN_DEFAULT       = 32;
  localparam int unsigned IBUF_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/miriscv_ld_scoreboard.sv
// Tracks GPRs with an outstanding load; x0 is never marked pending.
module miriscv_ld_scoreboard (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        set_en_i,
  input  logic [4:0]  set_addr_i,
  input  logic        clr_en_i,
  input  logic [4:0]  clr_addr_i,
  output logic [31:0] pending_o
);

  logic [31:0] r_pending;
  logic [31:0] w_pending_nxt;

  // Set is applied after clear so a same-register collision leaves the bit set.
  always_comb begin
    w_pending_nxt = r_pending;
    if (clr_en_i) w_pending_nxt[clr_addr_i] = 1'b0;
    if (set_en_i) w_pending_nxt[set_addr_i] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) r_pending <= '0;
    else          r_pending <= w_pending_nxt;
  end

  assign pending_o = r_pending;

endmodule

// File: rtl/miriscv_decode_ibuf.sv
// Decode-side instruction buffer: circular FIFO between fetch and decode,
// holding back the head entry while a load it depends on is still in flight.
module miriscv_decode_ibuf
  import miriscv_pkg::*;
  import miriscv_decode_pkg::*;
#(
  parameter int unsigned IBUF_DEPTH = IBUF_DEPTH_DEFAULT,
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned ILEN       = ILEN_DEFAULT
) (
  input  logic                            clk_i,
  input  logic                            arstn_i,
  input  logic                            f_valid_i,
  input  logic [ILEN-1:0]                 f_instr_i,
  input  logic [XLEN-1:0]                 f_current_pc_i,
  input  logic [XLEN-1:0]                 f_next_pc_i,
  output logic                            f_ready_o,
  input  logic                            cu_kill_d_i,
  input  logic                            d_ready_i,
  output logic                            d_valid_o,
  output logic [ILEN-1:0]                 d_instr_o,
  output logic [XLEN-1:0]                 d_current_pc_o,
  output logic [XLEN-1:0]                 d_next_pc_o,
  input  logic                            m_gpr_wr_en_i,
  input  logic [4:0]                      m_gpr_wr_addr_i,
  output logic                            d_stall_req_o,
  output logic [$clog2(IBUF_DEPTH+1)-1:0] ibuf_count_o
);

  localparam int unsigned PTR_W = $clog2(IBUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(IBUF_DEPTH + 1);

  logic [ILEN-1:0]  r_instr   [IBUF_DEPTH];
  logic [XLEN-1:0]  r_cur_pc  [IBUF_DEPTH];
  logic [XLEN-1:0]  r_next_pc [IBUF_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [ILEN-1:0]  w_head_instr;
  logic [6:0]       w_opcode;
  logic [4:0]       w_rd;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [31:0]      w_pending;
  logic             w_empty;
  logic             w_hazard;
  logic             w_push;
  logic             w_pop;
  logic             w_ld_set;

  assign w_head_instr = r_instr[r_rd_ptr];
  assign w_opcode     = w_head_instr[6:0];
  assign w_rd         = w_head_instr[11:7];
  assign w_rs1        = w_head_instr[19:15];
  assign w_rs2        = w_head_instr[24:20];

  assign w_empty  = (r_count == '0);
  assign w_hazard = ~w_empty & ((uses_rs1(w_opcode) & w_pending[w_rs1]) |
                                (uses_rs2(w_opcode) & w_pending[w_rs2]));

  // Kill gates both handshakes so a flushed cycle neither pushes nor pops.
  assign f_ready_o     = (r_count < CNT_W'(IBUF_DEPTH)) & ~cu_kill_d_i;
  assign d_valid_o     = ~w_empty & ~w_hazard & ~cu_kill_d_i;
  assign d_stall_req_o = w_hazard;
  assign w_push        = f_valid_i & f_ready_o;
  assign w_pop         = d_valid_o & d_ready_i;
  assign w_ld_set      = w_pop & (w_opcode == OPC_LOAD) & (w_rd != 5'd0);

  assign d_instr_o      = w_head_instr;
  assign d_current_pc_o = r_cur_pc[r_rd_ptr];
  assign d_next_pc_o    = r_next_pc[r_rd_ptr];
  assign ibuf_count_o   = r_count;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_instr[r_wr_ptr]   <= f_instr_i;
      r_cur_pc[r_wr_ptr]  <= f_current_pc_i;
      r_next_pc[r_wr_ptr] <= f_next_pc_i;
    end
  end

  // Power-of-two depth lets pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (!arstn_i || cu_kill_d_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  miriscv_ld_scoreboard u_ld_scoreboard (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .set_en_i   (w_ld_set),
    .set_addr_i (w_rd),
    .clr_en_i   (m_gpr_wr_en_i),
    .clr_addr_i (m_gpr_wr_addr_i),
    .pending_o  (w_pending)
  );

endmodule

// File: tb/tb_miriscv_decode_ibuf.sv
// Self-checking bench for miriscv_decode_ibuf: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_miriscv_decode_ibuf;

  localparam int unsigned DEPTH = 4;

  localparam logic [31:0] I_NOP     = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] I_LW_X5   = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD_X5  = 32'h0012_8333; // add  x6,x5,x1
  localparam logic [31:0] I_LUI_X5  = 32'h0000_52B7; // lui  x5,5
  localparam logic [31:0] I_LW_X0   = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADD_X0  = 32'h0000_0333; // add  x6,x0,x0

  logic        clk = 1'b0;
  logic        arstn;
  logic        f_valid;
  logic [31:0] f_instr;
  logic [31:0] f_cur_pc;
  logic [31:0] f_next_pc;
  logic        f_ready;
  logic        kill;
  logic        d_ready;
  logic        d_valid;
  logic [31:0] d_instr;
  logic [31:0] d_cur_pc;
  logic [31:0] d_next_pc;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic        stall;
  logic [2:0]  count;

  always #5 clk = ~clk;

  miriscv_decode_ibuf #(.IBUF_DEPTH(DEPTH), .XLEN(32), .ILEN(32)) dut (
    .clk_i           (clk),
    .arstn_i         (arstn),
    .f_valid_i       (f_valid),
    .f_instr_i       (f_instr),
    .f_current_pc_i  (f_cur_pc),
    .f_next_pc_i     (f_next_pc),
    .f_ready_o       (f_ready),
    .cu_kill_d_i     (kill),
    .d_ready_i       (d_ready),
    .d_valid_o       (d_valid),
    .d_instr_o       (d_instr),
    .d_current_pc_o  (d_cur_pc),
    .d_next_pc_o     (d_next_pc),
    .m_gpr_wr_en_i   (wr_en),
    .m_gpr_wr_addr_i (wr_addr),
    .d_stall_req_o   (stall),
    .ibuf_count_o    (count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pend = '0;
  bit          m_live = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'b1100011, 7'b0100011, 7'b0110011};
  endfunction

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit rstn, input bit fv, input logic [31:0] instr,
                       input logic [31:0] pc, input bit kl, input bit dr,
                       input bit wen, input logic [4:0] waddr);
    int          cnt;
    bit          e_fr, e_dv, haz, set_b;
    logic [31:0] h;
    ent_t        e;
    arstn = rstn; f_valid = fv; f_instr = instr; f_cur_pc = pc; f_next_pc = pc + 32'd4;
    kill = kl; d_ready = dr; wr_en = wen; wr_addr = waddr;
    #2;
    if (m_live) begin
      cnt = q.size();
      haz = 1'b0;
      h   = '0;
      if (cnt != 0) begin
        h   = q[0].instr;
        haz = (reads_rs1(h[6:0]) && m_pend[h[19:15]]) || (reads_rs2(h[6:0]) && m_pend[h[24:20]]);
      end
      e_fr = (cnt < DEPTH) && !kl;
      e_dv = (cnt != 0) && !haz && !kl;
      chk("f_ready", 32'(f_ready), 32'(e_fr));
      chk("d_valid", 32'(d_valid), 32'(e_dv));
      chk("stall",   32'(stall),   32'(haz));
      chk("count",   32'(count),   32'(cnt));
      if (cnt != 0) begin
        chk("head_instr", d_instr,   q[0].instr);
        chk("head_pc",    d_cur_pc,  q[0].pc);
        chk("head_npc",   d_next_pc, q[0].npc);
      end
      set_b = 1'b0;
      if (!rstn) begin
        q.delete();
        m_pend = '0;
      end else begin
        if (kl) q.delete();
        else begin
          if (e_dv && dr) begin
            e = q.pop_front();
            if (e.instr[6:0] == 7'b0000011 && e.instr[11:7] != 5'd0) set_b = 1'b1;
            h = e.instr;
          end
          if (fv && e_fr) q.push_back('{instr: instr, pc: pc, npc: pc + 32'd4});
        end
        if (wen)   m_pend[waddr] = 1'b0;
        if (set_b) m_pend[h[11:7]] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_peek();
    arstn = 1'b1; f_valid = 1'b0; kill = 1'b0; d_ready = 1'b0; wr_en = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9];
    logic [4:0] rd, rs1, rs2;
    ops = '{7'b0000011, 7'b0000011, 7'b0110011, 7'b0010011, 7'b0100011,
            7'b1100011, 7'b1100111, 7'b0110111, 7'b1101111};
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    return {7'd0, rs2, rs1, 3'b010, rd, ops[$urandom_range(0, 8)]};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    arstn = 1'b0; f_valid = 1'b0; f_instr = '0; f_cur_pc = '0; f_next_pc = '0;
    kill = 1'b0; d_ready = 1'b0; wr_en = 1'b0; wr_addr = '0;
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    m_live = 1'b1;

    idle_peek();
    chk("rst_count",   32'(count),   32'd0);
    chk("rst_f_ready", 32'(f_ready), 32'd1);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_stall",   32'(stall),   32'd0);

    // Fill beyond capacity with decode stalled
    for (int i = 0; i < 5; i++) cycle(1, 1, I_NOP, 32'h100 + 32'(4 * i), 0, 0, 0, 0);
    idle_peek();
    chk("fill_count",   32'(count),   32'd4);
    chk("fill_f_ready", 32'(f_ready), 32'd0);
    chk("fill_head_pc", d_cur_pc,     32'h100);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0, 1, 0, 0);

    // In-order issue, one cycle after each push
    cycle(1, 1, I_NOP, 32'h0, 0, 1, 0, 0);
    idle_peek();
    chk("order_head0", d_cur_pc, 32'h0);
    cycle(1, 1, I_NOP, 32'h4, 0, 1, 0, 0);
    idle_peek();
    chk("order_head4", d_cur_pc, 32'h4);
    cycle(1, 1, I_NOP, 32'h8, 0, 1, 0, 0);
    idle_peek();
    chk("order_head8", d_cur_pc, 32'h8);
    cycle(1, 0, 0, 0, 0, 1, 0, 0);

    // Load-use stall until write-back of x5
    cycle(1, 1, I_LW_X5,  32'h200, 0, 1, 0, 0);
    cycle(1, 1, I_ADD_X5, 32'h204, 0, 1, 0, 0);
    idle_peek();
    chk("lu_stall",   32'(stall),   32'd1);
    chk("lu_d_valid", 32'(d_valid), 32'd0);
    cycle(1, 0, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 1, 5'd5);
    idle_peek();
    chk("lu_release", 32'(d_valid), 32'd1);
    cycle(1, 0, 0, 0, 0, 1, 0, 0);

    // LUI writing a pending register does not stall; lw x0 sets nothing
    cycle(1, 1, I_LW_X5,  32'h300, 0, 1, 0, 0);
    cycle(1, 1, I_LUI_X5, 32'h304, 0, 1, 0, 0);
    idle_peek();
    chk("lui_d_valid", 32'(d_valid), 32'd1);
    cycle(1, 0, 0, 0, 0, 1, 1, 5'd5);
    cycle(1, 1, I_LW_X0,  32'h308, 0, 1, 0, 0);
    cycle(1, 1, I_ADD_X0, 32'h30C, 0, 1, 0, 0);
    idle_peek();
    chk("x0_no_stall", 32'(d_valid), 32'd1);
    cycle(1, 0, 0, 0, 0, 1, 0, 0);

    // Kill with three entries; pending x5 survives the flush
    cycle(1, 1, I_LW_X5,  32'h400, 0, 1, 0, 0);
    cycle(1, 1, I_ADD_X5, 32'h404, 0, 1, 0, 0);
    cycle(1, 1, I_NOP,    32'h408, 0, 0, 0, 0);
    cycle(1, 1, I_NOP,    32'h40C, 0, 0, 0, 0);
    idle_peek();
    chk("kill_pre_count", 32'(count), 32'd3);
    cycle(1, 1, I_NOP, 32'h410, 1, 1, 0, 0);
    idle_peek();
    chk("kill_count", 32'(count), 32'd0);
    cycle(1, 1, I_ADD_X5, 32'h500, 0, 1, 0, 0);
    idle_peek();
    chk("kill_pend_kept", 32'(stall), 32'd1);
    cycle(1, 0, 0, 0, 0, 1, 1, 5'd5);
    cycle(1, 0, 0, 0, 0, 1, 0, 0);

    // Reset mid-operation overrides push/pop/kill
    cycle(1, 1, I_NOP, 32'h600, 0, 0, 0, 0);
    cycle(1, 1, I_NOP, 32'h604, 0, 0, 0, 0);
    cycle(0, 1, I_NOP, 32'h608, 1, 1, 0, 0);
    idle_peek();
    chk("midrst_count", 32'(count), 32'd0);

    // Back-to-back push/pop across pointer wrap
    cycle(1, 1, I_NOP, 32'h700, 0, 1, 0, 0);
    for (int i = 1; i <= 10; i++) cycle(1, 1, I_NOP, 32'h700 + 32'(4 * i), 0, 1, 0, 0);
    idle_peek();
    chk("wrap_count", 32'(count), 32'd1);
    chk("wrap_head",  d_cur_pc,   32'h728);
    cycle(1, 0, 0, 0, 0, 1, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, rand_instr(),
            32'($urandom) & 32'hFFFF_FFFC, $urandom_range(0, 24) == 0,
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
            5'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
